// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a transmit requester and uart_tx_ctrl.
interface uart_tx_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving an external 8-bit PISO: framing, baud timing, load/shift strobes.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit(s).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_ctrl_if.slave     tx_if,
  output logic [7:0]        piso_data,
  output logic              piso_load,
  output logic              piso_shift,
  input  logic              piso_bit,
  output logic              tx,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    STOP_LAST    = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          tx_q;
  logic          accept;
  logic          baud_end;
  logic          baud_prelast;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign tx_if.tx_ready = (state == IDLE) && !rst;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign baud_end       = (baud_cnt == BAUD_LAST);
  assign baud_prelast   = (baud_cnt == BAUD_PRELAST);

  // During DATA the PISO output goes straight to the line so each bit appears the cycle it is shifted out.
  assign tx = (state == DATA) ? piso_bit : tx_q;

  // Strobes are registered one cycle ahead, so shift is raised when the baud counter is one short of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_q       <= 1'b1;
      busy       <= 1'b0;
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      piso_data  <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            piso_data <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
            parity    <= ^tx_if.tx_data;
`endif
            state     <= START;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            busy      <= 1'b1;
            piso_load <= 1'b1;
          end
        end

        START: begin
          piso_shift <= baud_prelast;
          if (baud_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          piso_shift <= baud_prelast && (bit_cnt != 3'd7);
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_q    <= parity;
`else
              state   <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            state    <= STOP;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          tx_q <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: one DUT with one stop bit, one with two, both at 4 clocks per bit.
// Expected line levels and strobes come from a frame-bit model; a behavioural PISO feeds piso_bit.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] valid_d;
  logic [7:0] data_d [2];
  logic [1:0] rdy_o, tx_o, busy_o, load_o, shift_o, pbit;
  logic [7:0] pd_o [2];
  logic [7:0] sr [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if ifc0 ();
  uart_tx_ctrl_if ifc1 ();

  assign ifc0.tx_data  = data_d[0];
  assign ifc0.tx_valid = valid_d[0];
  assign ifc1.tx_data  = data_d[1];
  assign ifc1.tx_valid = valid_d[1];
  assign rdy_o[0]      = ifc0.tx_ready;
  assign rdy_o[1]      = ifc1.tx_ready;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_if(ifc0),
    .piso_data(pd_o[0]), .piso_load(load_o[0]), .piso_shift(shift_o[0]),
    .piso_bit(pbit[0]), .tx(tx_o[0]), .busy(busy_o[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_if(ifc1),
    .piso_data(pd_o[1]), .piso_load(load_o[1]), .piso_shift(shift_o[1]),
    .piso_bit(pbit[1]), .tx(tx_o[1]), .busy(busy_o[1])
  );

  // Behavioural PISO: registered serial output, LSB first, advancing on each shift strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_o[i]) sr[i] <= pd_o[i];
      else if (shift_o[i]) begin
        pbit[i] <= sr[i][0];
        sr[i]   <= sr[i] >> 1;
      end
    end
  end

  function automatic int stop_bits(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int u);
    return (1 + 8 + PAR + stop_bits(u)) * CPB;
  endfunction

  // Line level in frame cycle k (k=1 is the first START cycle): start, d0..d7, [parity], stop(s).
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic exp_shift(input int k);
    return (k % CPB == 0) && (k / CPB >= 1) && (k / CPB <= 8);
  endfunction

  task automatic start_frame(input int u, input logic [7:0] d);
    int n;
    n = 0;
    while (rdy_o[u] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy_o[u] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_wait dut%0d: tx_ready=%b expected 1", u, rdy_o[u]);
    end
    valid_d[u] = 1'b1;
    data_d[u]  = d;
  endtask

  // Called right after the accept negedge; checks every frame cycle and the first idle cycle after it.
  task automatic run_frame(input int u, input logic [7:0] d, input bit hold, input bit noise, input int next);
    int f, nload, nshift, nbusy;
    f = frame_len(u);
    nload = 0; nshift = 0; nbusy = 0;
    for (int k = 1; k <= f; k++) begin
      @(negedge clk);
      if (!hold) valid_d[u] = 1'b0;
      if (noise) begin
        valid_d[u] = 1'($urandom_range(0, 1));
        data_d[u]  = 8'($urandom);
      end
      checks++;
      if (tx_o[u] !== exp_tx(d, k)) begin
        errors++;
        $display("[TB] FAIL tx dut%0d k=%0d: got %b expected %b", u, k, tx_o[u], exp_tx(d, k));
      end
      checks++;
      if (busy_o[u] !== 1'b1 || rdy_o[u] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_ready dut%0d k=%0d: busy=%b ready=%b expected 1/0", u, k, busy_o[u], rdy_o[u]);
      end
      checks++;
      if (load_o[u] !== (k == 1)) begin
        errors++;
        $display("[TB] FAIL load dut%0d k=%0d: got %b expected %b", u, k, load_o[u], (k == 1));
      end
      checks++;
      if (shift_o[u] !== exp_shift(k)) begin
        errors++;
        $display("[TB] FAIL shift dut%0d k=%0d: got %b expected %b", u, k, shift_o[u], exp_shift(k));
      end
      checks++;
      if (pd_o[u] !== d) begin
        errors++;
        $display("[TB] FAIL piso_data dut%0d k=%0d: got %h expected %h", u, k, pd_o[u], d);
      end
      nload  += int'(load_o[u] === 1'b1);
      nshift += int'(shift_o[u] === 1'b1);
      nbusy  += int'(busy_o[u] === 1'b1);
    end
    @(negedge clk);
    checks++;
    if (busy_o[u] !== 1'b0 || rdy_o[u] !== 1'b1 || tx_o[u] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_end dut%0d: busy=%b ready=%b tx=%b expected 0/1/1", u, busy_o[u], rdy_o[u], tx_o[u]);
    end
    checks++;
    if (nload != 1 || nshift != 8 || nbusy != f) begin
      errors++;
      $display("[TB] FAIL strobe_counts dut%0d: loads=%0d shifts=%0d busy=%0d expected 1/8/%0d", u, nload, nshift, nbusy, f);
    end
    if (next >= 0) begin
      valid_d[u] = 1'b1;
      data_d[u]  = 8'(next);
    end else begin
      valid_d[u] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_d = '0;
    data_d[0] = '0;
    data_d[1] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (tx_o[u] !== 1'b1 || busy_o[u] !== 1'b0 || load_o[u] !== 1'b0 || shift_o[u] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: tx=%b busy=%b load=%b shift=%b expected 1/0/0/0",
                 u, tx_o[u], busy_o[u], load_o[u], shift_o[u]);
      end
      checks++;
      if (pd_o[u] !== 8'h00 || rdy_o[u] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_data_ready dut%0d: piso_data=%h ready=%b expected 00/0", u, pd_o[u], rdy_o[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_o !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b expected 11", rdy_o);
    end
  endtask

  task automatic test_single_byte();
    start_frame(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h00);
    run_frame(0, 8'h00, 1'b1, 1'b0, 8'hFF);
    run_frame(0, 8'hFF, 1'b0, 1'b0, -1);
  endtask

  task automatic test_two_stop();
    logic [7:0] d;
    d = 8'($urandom);
    start_frame(1, d);
    run_frame(1, d, 1'b0, 1'b0, -1);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    start_frame(0, 8'h07);
    run_frame(0, 8'h07, 1'b0, 1'b0, -1);
    start_frame(0, 8'h03);
    run_frame(0, 8'h03, 1'b0, 1'b0, -1);
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom);
    start_frame(0, d);
    for (int k = 1; k <= 4 * CPB + 1; k++) begin
      @(negedge clk);
      valid_d[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || load_o[0] !== 1'b0 || shift_o[0] !== 1'b0 || rdy_o[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: tx=%b busy=%b load=%b shift=%b ready=%b expected 1/0/0/0/0",
               tx_o[0], busy_o[0], load_o[0], shift_o[0], rdy_o[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    start_frame(0, 8'h5A);
    run_frame(0, 8'h5A, 1'b0, 1'b0, -1);
  endtask

  task automatic test_ignored_input();
    logic [7:0] d;
    d = 8'($urandom);
    start_frame(0, d);
    run_frame(0, d, 1'b0, 1'b1, -1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1 || load_o[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_extra_accept: busy=%b tx=%b load=%b expected 0/1/0", busy_o[0], tx_o[0], load_o[0]);
      end
    end
  endtask

  task automatic test_random();
    int u;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      u = int'($urandom_range(0, 1));
      d = 8'($urandom);
      start_frame(u, d);
      run_frame(u, d, 1'b0, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_two_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_ignored_input();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

- Transmit-side sequencer for the 8-bit PISO shift register in the UART datapath.
- Accepts a byte over a valid/ready handshake, forwards it to the PISO and pulses its load strobe.
- Generates the baud timing and pulses the PISO shift strobe once per data bit.
- Drives the serial line with start bit, the PISO output bit, optional parity, and stop bit(s).

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (868 = 100 MHz / 115200); legal range 4..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- tx_data  input  8  byte to transmit; sampled on the accept cycle.
- tx_valid  input  1  requester has a byte.
- tx_ready  output  1  controller can accept. Equals (state==IDLE && !rst).
- piso_data  output  8  registered copy of the accepted byte, wired to the PISO parallel input.
- piso_load  output  1  one-cycle PISO load strobe.
- piso_shift  output  1  one-cycle PISO shift strobe.
- piso_bit  input  1  PISO serial output; LSB first; updates the cycle after each shift strobe.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.

## Operation
- **Reset values:**
  - Registered outputs: tx=1, busy=0, piso_load=0, piso_shift=0, piso_data=0.
  - tx_ready=0 while rst is high (it is combinational).
  - Internal: state=IDLE, baud counter=0, bit counter=0.
- **States:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE:**
  - tx=1.
  - On tx_valid && tx_ready (the accept cycle): register tx_data into piso_data and compute the parity bit; go to START.
  - The load strobe is asserted on the first START cycle, since piso_data is only valid from then.
- **START:**
  - tx=0 for CLKS_PER_BIT cycles.
  - piso_load=1 on the first START cycle only.
  - piso_shift=1 on the last cycle, so bit 0 is present on piso_bit at DATA entry.
- **DATA:**
  - tx=piso_bit for 8 bit periods.
  - The bit counter runs 0..7.
  - piso_shift=1 on the last cycle of bit periods 0..6 only; it is never asserted on the final data bit (8 shifts per frame in total).
  - After bit 7, go to PARITY if the macro is defined, otherwise STOP.
- **PARITY:** tx=parity bit for CLKS_PER_BIT cycles.
- **STOP:**
  - tx=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- **Baud counter:**
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every state or bit transition.
  - Width is $clog2(CLKS_PER_BIT).
- **Strobe rules:** piso_load and piso_shift are never high in the same cycle, and neither is high outside START or DATA.
- **Handshake:**
  - tx_data/tx_valid are ignored while busy.
  - The requester may hold tx_valid high. The next byte is accepted in the single IDLE cycle after STOP, so consecutive frames are separated by exactly one extra idle-high clock.
- **Reset mid-frame:**
  - The cycle after rst is sampled high: tx=1, state=IDLE, all strobes 0.
  - The partial frame is abandoned.
  - Stale PISO contents are harmless because every frame starts with a load.

## Timing
- Accept at cycle T. START begins at T+1: tx falls, piso_load=1. Bit 0 appears on tx at T+1+CLKS_PER_BIT.
- Frame length from T+1:
  - (10 + STOP_BITS - 1) × CLKS_PER_BIT cycles.
  - Add CLKS_PER_BIT with parity.
- busy rises at T+1 and falls on the cycle after the last stop-bit cycle. tx_ready rises in that same cycle.
- piso_bit must be valid one cycle after piso_shift. The PISO's registered output meets this with no slack required from the controller.

## Configuration
- **UART_TX_PARITY_EN** defined:
  - PARITY state is compiled in.
  - The parity bit is even parity, the XOR of the 8 accepted bits, captured at accept.
  - The frame grows by one bit period.
- **UART_TX_PARITY_EN** undefined: no PARITY state and no parity register; DATA goes directly to STOP.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, send 0xA5.
  - tx pattern (one entry per bit, 4 clocks each): 0,1,0,1,0,0,1,0,1,1.
  - One piso_load at T+1; exactly 8 piso_shift pulses, at T+4, T+8, …, T+32.
- **Back-to-back:** tx_valid held high, bytes 0x00 then 0xFF.
  - Second accept occurs exactly one cycle after the first frame's stop bit ends.
  - tx_ready is low throughout each frame.
- **Parity (macro defined):** send 0x07.
  - Parity bit = 1, placed between bit 7 and stop.
  - Send 0x03: parity bit = 0.
- **Two stop bits:** STOP_BITS=2, CLKS_PER_BIT=4.
  - tx is high for 8 clocks after bit 7.
  - busy is high for exactly 44 cycles.
- **Reset mid-frame:** assert rst at data bit 3.
  - Next cycle: tx=1, busy=0, no strobes.
  - A new byte 0x5A is then transmitted correctly.
- **Ignored input:** toggle tx_valid and tx_data while busy. The frame is unchanged and no extra accept occurs.
